// File: rtl/seven_segment_value_controller.sv
// Value-to-BCD sequencer for the four-digit seven-segment driver: handshake in, double-dabble, atomic publish.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_segment_value_controller #(
  parameter int unsigned BIN_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIN_WIDTH-1:0] bin_in,
  input  logic [3:0]           dp_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [15:0]          bcd_out,
  output logic [3:0]           decimal_points,
  output logic                 overflow,
  output logic                 update_done
);

  localparam int unsigned CNT_W   = $clog2(BIN_WIDTH + 1);
  localparam int unsigned CAT_W   = 16 + BIN_WIDTH;
  localparam int unsigned MAX_DEC = 9999;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_PUBLISH
  } state_e;

  state_e               state_q;
  logic [BIN_WIDTH-1:0] shift_q;
  logic [15:0]          scratch_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [3:0]           dp_q;
  logic                 ovf_q;

  logic [15:0]          adj_d;
  logic [CAT_W-1:0]     cat_d;
  logic [15:0]          pub_d;

  assign in_ready = (state_q == S_IDLE);

  // Add-3 correction on every nibble, then the combined left shift.
  always_comb begin
    adj_d = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    cat_d = {adj_d, shift_q} << 1;
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic blank_d;

  // Blank leading zeros of digits 3..1 until a nonzero digit or a lit decimal point.
  always_comb begin
    pub_d   = ovf_q ? 16'h9999 : scratch_q;
    blank_d = !ovf_q;
    for (int i = 3; i >= 1; i--) begin
      if (blank_d && (scratch_q[4*i +: 4] == 4'd0) && !dp_q[i]) begin
        pub_d[4*i +: 4] = 4'hF;
      end else begin
        blank_d = 1'b0;
      end
    end
  end
`else
  always_comb begin
    pub_d = ovf_q ? 16'h9999 : scratch_q;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      shift_q        <= '0;
      scratch_q      <= '0;
      cnt_q          <= '0;
      dp_q           <= '0;
      ovf_q          <= 1'b0;
      bcd_out        <= '0;
      decimal_points <= '0;
      overflow       <= 1'b0;
      update_done    <= 1'b0;
    end else begin
      update_done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            shift_q   <= bin_in;
            dp_q      <= dp_in;
            ovf_q     <= (32'(bin_in) > 32'(MAX_DEC));
            scratch_q <= '0;
            cnt_q     <= CNT_W'(BIN_WIDTH);
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scratch_q <= cat_d[CAT_W-1:BIN_WIDTH];
          shift_q   <= cat_d[BIN_WIDTH-1:0];
          cnt_q     <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_PUBLISH;
        end
        S_PUBLISH: begin
          bcd_out        <= pub_d;
          decimal_points <= dp_q;
          overflow       <= ovf_q;
          update_done    <= 1'b1;
          state_q        <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_segment_value_controller.sv
// Self-checking bench for seven_segment_value_controller; honours SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module tb_seven_segment_value_controller;

  localparam int BW  = 14;
  localparam int LAT = BW + 1;

  logic          clk;
  logic          reset;
  logic [BW-1:0] bin_in;
  logic [3:0]    dp_in;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   bcd_out;
  logic [3:0]    decimal_points;
  logic          overflow;
  logic          update_done;

  int checks = 0;
  int errors = 0;

  seven_segment_value_controller #(.BIN_WIDTH(BW)) dut (
    .clk            (clk),
    .reset          (reset),
    .bin_in         (bin_in),
    .dp_in          (dp_in),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .bcd_out        (bcd_out),
    .decimal_points (decimal_points),
    .overflow       (overflow),
    .update_done    (update_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by division, saturation, optional blanking.
  function automatic logic [15:0] model_bcd(input int v, input logic [3:0] dp);
    logic [15:0] r;
    int x;
    if (v > 9999) return 16'h9999;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    for (int i = 3; i >= 1; i--) begin
      if (r[4*i +: 4] == 4'd0 && !dp[i]) r[4*i +: 4] = 4'hF;
      else break;
    end
`else
    if (dp == 4'hF) r = r;
`endif
    return r;
  endfunction

  // Drive one transaction and observe it; lat = -1 when no publish appears.
  task automatic run_conv(input int v, input logic [3:0] dp, input bit hold_valid,
                          input int glitch_cycle, output int lat, output logic [15:0] b,
                          output logic [3:0] d, output logic o, output int held_bad,
                          output int busy_bad);
    logic [15:0] pb;
    logic [3:0]  pd;
    logic        po;
    pb = bcd_out; pd = decimal_points; po = overflow;
    lat = -1; held_bad = 0; busy_bad = 0; b = '0; d = '0; o = 1'b0;
    @(negedge clk);
    bin_in = BW'(v); dp_in = dp; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = hold_valid;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == glitch_cycle) begin
        bin_in = '0; in_valid = 1'b1;
      end else if (!hold_valid) begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (update_done) begin
        lat = n; b = bcd_out; d = decimal_points; o = overflow;
        break;
      end
      if (bcd_out !== pb || decimal_points !== pd || overflow !== po) held_bad++;
      if (in_ready !== 1'b0) busy_bad++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || bcd_out !== 16'h0 || decimal_points !== 4'h0 ||
        overflow !== 1'b0 || update_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b bcd=%h dp=%b ovf=%b upd=%b required 1 0000 0000 0 0",
               in_ready, bcd_out, decimal_points, overflow, update_done);
    end
  endtask

  task automatic test_basic();
    int lat, hb, bb;
    logic [15:0] b;
    logic [3:0] d;
    logic o;
    run_conv(1234, 4'b0010, 1'b0, 0, lat, b, d, o, hb, bb);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL basic_latency: got %0d required %0d", lat, LAT); end
    checks++;
    if (b !== 16'h1234 || d !== 4'b0010 || o !== 1'b0) begin
      errors++; $display("FAIL basic_value: got %h/%b/%b required 1234/0010/0", b, d, o);
    end
    checks++;
    if (bb !== 0) begin errors++; $display("FAIL basic_busy: in_ready high %0d SHIFT cycles", bb); end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || update_done !== 1'b0) begin
      errors++; $display("FAIL basic_after: rdy=%b upd=%b required 1 0", in_ready, update_done);
    end
  endtask

  task automatic test_boundaries();
    int vals[5] = '{9999, 10000, 16383, 42, 0};
    int lat, hb, bb;
    logic [15:0] b;
    logic [3:0] d;
    logic o;
    for (int i = 0; i < 5; i++) begin
      run_conv(vals[i], 4'b0000, 1'b0, 0, lat, b, d, o, hb, bb);
      checks++;
      if (lat !== LAT || b !== model_bcd(vals[i], 4'b0000) || o !== (vals[i] > 9999)) begin
        errors++;
        $display("FAIL boundary_%0d: lat=%0d bcd=%h ovf=%b required lat=%0d bcd=%h ovf=%b",
                 vals[i], lat, b, o, LAT, model_bcd(vals[i], 4'b0000), vals[i] > 9999);
      end
    end
  endtask

  task automatic test_blank();
    int vals[4] = '{7, 0, 5, 1004};
    logic [3:0] dps[4] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
    int lat, hb, bb;
    logic [15:0] b;
    logic [3:0] d;
    logic o;
    for (int i = 0; i < 4; i++) begin
      run_conv(vals[i], dps[i], 1'b0, 0, lat, b, d, o, hb, bb);
      checks++;
      if (b !== model_bcd(vals[i], dps[i]) || d !== dps[i]) begin
        errors++;
        $display("FAIL blank_%0d: bcd=%h dp=%b required bcd=%h dp=%b",
                 vals[i], b, d, model_bcd(vals[i], dps[i]), dps[i]);
      end
    end
  endtask

  task automatic test_random();
    int v, lat, hb, bb;
    logic [3:0] dp;
    logic [15:0] b;
    logic [3:0] d;
    logic o;
    for (int i = 0; i < 16; i++) begin
      v  = int'($urandom_range(0, 16383));
      dp = 4'($urandom);
      run_conv(v, dp, 1'b0, 0, lat, b, d, o, hb, bb);
      checks++;
      if (lat !== LAT || b !== model_bcd(v, dp) || d !== dp || o !== (v > 9999) || hb !== 0) begin
        errors++;
        $display("FAIL random_%0d: lat=%0d bcd=%h dp=%b ovf=%b hold=%0d required %0d %h %b %b 0",
                 v, lat, b, d, o, hb, LAT, model_bcd(v, dp), dp, v > 9999);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, hb, bb, pulses;
    logic [15:0] b;
    logic [3:0] d;
    logic o;
    run_conv(1234, 4'b0000, 1'b0, 0, lat, b, d, o, hb, bb);
    checks++;
    if (b !== model_bcd(1234, 4'b0000)) begin
      errors++; $display("FAIL b2b_first: got %h required %h", b, model_bcd(1234, 4'b0000));
    end
    run_conv(5678, 4'b0000, 1'b1, 0, lat, b, d, o, hb, bb);
    checks++;
    if (hb !== 0 || bb !== 0) begin
      errors++; $display("FAIL b2b_hold: changed=%0d busy_ready=%0d required 0 0", hb, bb);
    end
    checks++;
    if (lat !== LAT || b !== 16'h5678) begin
      errors++; $display("FAIL b2b_second: lat=%0d bcd=%h required %0d 5678", lat, b, LAT);
    end
    pulses = 0;
    repeat (LAT + 3) begin
      @(posedge clk);
      #1;
      if (update_done) pulses++;
    end
    checks++;
    if (pulses !== 0 || in_ready !== 1'b1 || bcd_out !== 16'h5678) begin
      errors++;
      $display("FAIL b2b_single: extra pulses=%0d rdy=%b bcd=%h required 0 1 5678", pulses, in_ready, bcd_out);
    end
  endtask

  task automatic test_busy_ignore();
    int lat, hb, bb;
    logic [15:0] b;
    logic [3:0] d;
    logic o;
    run_conv(4321, 4'b0000, 1'b0, 4, lat, b, d, o, hb, bb);
    checks++;
    if (lat !== LAT || b !== 16'h4321 || hb !== 0) begin
      errors++; $display("FAIL busy_ignore: lat=%0d bcd=%h changed=%0d required %0d 4321 0", lat, b, hb, LAT);
    end
  endtask

  task automatic test_reset_mid();
    int pulses, lat, hb, bb;
    logic [15:0] b;
    logic [3:0] d;
    logic o;
    @(negedge clk);
    bin_in = BW'(2222); dp_in = 4'b1000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (bcd_out !== 16'h0 || decimal_points !== 4'h0 || overflow !== 1'b0 ||
        update_done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: bcd=%h dp=%b ovf=%b upd=%b rdy=%b required 0000 0000 0 0 1",
               bcd_out, decimal_points, overflow, update_done, in_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (LAT + 3) begin
      @(posedge clk);
      #1;
      if (update_done || bcd_out !== 16'h0) pulses++;
    end
    checks++;
    if (pulses !== 0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_nopublish: events=%0d rdy=%b required 0 1", pulses, in_ready);
    end
    run_conv(1, 4'b0000, 1'b0, 0, lat, b, d, o, hb, bb);
    checks++;
    if (lat !== LAT || b !== model_bcd(1, 4'b0000)) begin
      errors++; $display("FAIL reset_recover: lat=%0d bcd=%h required %0d %h", lat, b, LAT, model_bcd(1, 4'b0000));
    end
  endtask

  initial begin
    reset = 1'b1; bin_in = '0; dp_in = '0; in_valid = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_basic();
    test_boundaries();
    test_blank();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
